// File: rtl/reg_serial_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module  : reg_serial_tx_pkg
// Brief   : Shared state encodings and line levels for the serial tx/rx pair.
// Revision: 1.0 - initial release
// ============================================================================
package reg_serial_tx_pkg;

    localparam int WORD_WIDTH = 16;

    typedef logic [2:0] state_t;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

    // True while a frame occupies the line (start, data or stop bit).
    function automatic logic is_active(input logic [2:0] s);
        return (s == ST_START) || (s == ST_DATA) || (s == ST_STOP);
    endfunction

endpackage : reg_serial_tx_pkg
`default_nettype wire

// File: rtl/reg_serial_tx_bit_timer.sv
`default_nettype none
// ============================================================================
// Module  : reg_serial_tx_bit_timer
// Brief   : Bit-period counter with enable, sync clear and terminal-count pulse.
// Revision: 1.0 - initial release
// ============================================================================
module reg_serial_tx_bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tc
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_count;

    // With one clock per bit c_LAST is zero, so the count never leaves 0.
    assign o_tc = i_en && (r_count == c_LAST);

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_count <= '0;
        end else if (o_tc) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule : reg_serial_tx_bit_timer
`default_nettype wire

// File: rtl/reg_serial_tx.sv
`default_nettype none
// ============================================================================
// Module  : reg_serial_tx
// Brief   : Loads a word and shifts it out as start / data / stop serial frame.
// Revision: 1.0 - initial release
// ============================================================================
module reg_serial_tx
    import reg_serial_tx_pkg::*;
#(
    parameter int WIDTH        = WORD_WIDTH,
    parameter int CLKS_PER_BIT = 4,
    parameter int MSB_FIRST    = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             load,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    localparam int BIT_W = $clog2(WIDTH + 1);
    localparam logic [BIT_W-1:0] c_LAST_BIT = BIT_W'(WIDTH - 1);

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] w_next_shift;
    logic [WIDTH-1:0] w_shifted;
    logic [BIT_W-1:0] r_bit_cnt;
    logic [BIT_W-1:0] w_next_bit_cnt;
    logic             r_sout;
    logic             r_busy;
    logic             r_done;
    logic             w_next_sout;
    logic             w_head;
    logic             w_accept;
    logic             w_timer_en;
    logic             w_tc;

    // DONE also accepts a load so consecutive frames run without an idle gap.
    assign w_accept   = load && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_timer_en = is_active(r_state);

    reg_serial_tx_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk   (clk),
        .rst   (reset),
        .i_en  (w_timer_en),
        .i_clr (w_accept),
        .o_tc  (w_tc)
    );

    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign w_shifted = {r_shift[WIDTH-2:0], 1'b0};
            assign w_head    = w_next_shift[WIDTH-1];
        end else begin : g_lsb_first
            assign w_shifted = {1'b0, r_shift[WIDTH-1:1]};
            assign w_head    = w_next_shift[0];
        end
    endgenerate

    always_comb begin
        w_next_state   = r_state;
        w_next_shift   = r_shift;
        w_next_bit_cnt = r_bit_cnt;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_accept) begin
                    w_next_state   = ST_START;
                    w_next_shift   = din;
                    w_next_bit_cnt = '0;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_START: begin
                if (w_tc) begin
                    w_next_state = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_tc) begin
                    w_next_shift = w_shifted;
                    if (r_bit_cnt == c_LAST_BIT) begin
                        w_next_state   = ST_STOP;
                        w_next_bit_cnt = '0;
                    end else begin
                        w_next_bit_cnt = r_bit_cnt + 1'b1;
                    end
                end
            end
            ST_STOP: begin
                if (w_tc) begin
                    w_next_state = ST_DONE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_comb begin
        w_next_sout = IDLE_LEVEL;
        case (w_next_state)
            ST_START: w_next_sout = START_LEVEL;
            ST_DATA:  w_next_sout = w_head;
            ST_STOP:  w_next_sout = STOP_LEVEL;
            default:  w_next_sout = IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_sout    <= IDLE_LEVEL;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_shift   <= w_next_shift;
            r_bit_cnt <= w_next_bit_cnt;
            r_sout    <= w_next_sout;
            r_busy    <= is_active(w_next_state);
            r_done    <= (w_next_state == ST_DONE);
        end
    end

    assign sout = r_sout;
    assign busy = r_busy;
    assign done = r_done;

endmodule : reg_serial_tx
`default_nettype wire

// File: tb/tb_reg_serial_tx.sv
`default_nettype none
// ============================================================================
// Module  : tb_reg_serial_tx
// Brief   : Self-checking bench for reg_serial_tx against a frame-level model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_reg_serial_tx;

    localparam int W     = 16;
    localparam int CPB_A = 4;
    localparam int CPB_B = 1;

    logic          clk = 1'b0;
    logic          a_reset, a_load, a_sout, a_busy, a_done;
    logic [W-1:0]  a_din;
    logic          b_reset, b_load, b_sout, b_busy, b_done;
    logic [W-1:0]  b_din;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    reg_serial_tx #(.WIDTH(W), .CLKS_PER_BIT(CPB_A), .MSB_FIRST(1)) dut_a (
        .clk(clk), .reset(a_reset), .din(a_din), .load(a_load),
        .sout(a_sout), .busy(a_busy), .done(a_done)
    );

    reg_serial_tx #(.WIDTH(W), .CLKS_PER_BIT(CPB_B), .MSB_FIRST(0)) dut_b (
        .clk(clk), .reset(b_reset), .din(b_din), .load(b_load),
        .sout(b_sout), .busy(b_busy), .done(b_done)
    );

    // Frame model: cycle k (k=1 is the cycle after the accepting edge).
    function automatic logic exp_sout(input logic [W-1:0] w, input int cpb, input bit msb, input int k);
        int b;
        b = (k - 1) / cpb;
        if (b == 0) return 1'b0;
        if (b <= W) return msb ? w[W - b] : w[b - 1];
        return 1'b1;
    endfunction

    function automatic logic exp_busy(input int cpb, input int k);
        return (k >= 1) && (k <= (W + 2) * cpb);
    endfunction

    function automatic logic exp_done(input int cpb, input int k);
        return k == (W + 2) * cpb + 1;
    endfunction

    task automatic test_reset();
        a_reset = 1'b1; a_load = 1'b0; a_din = '0;
        b_reset = 1'b1; b_load = 1'b0; b_din = '0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({a_sout, a_busy, a_done} !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_a got sout/busy/done=%b%b%b want 100", a_sout, a_busy, a_done);
        end
        n_tests++;
        if ({b_sout, b_busy, b_done} !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_b got sout/busy/done=%b%b%b want 100", b_sout, b_busy, b_done);
        end
        a_reset = 1'b0;
        b_reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_frame_a5c3();
        logic [W-1:0] w;
        int dones;
        w = 16'hA5C3; dones = 0;
        a_din = w; a_load = 1'b1;
        for (int k = 1; k <= 76; k++) begin
            @(negedge clk);
            a_load = 1'b0;
            a_din  = W'($urandom);
            dones += a_done ? 1 : 0;
            n_tests++;
            if ({a_sout, a_busy, a_done} !== {exp_sout(w, CPB_A, 1'b1, k), exp_busy(CPB_A, k), exp_done(CPB_A, k)}) begin
                n_fail++;
                $display("FAIL a5c3 k=%0d got %b%b%b want %b%b%b", k, a_sout, a_busy, a_done,
                         exp_sout(w, CPB_A, 1'b1, k), exp_busy(CPB_A, k), exp_done(CPB_A, k));
            end
        end
        n_tests++;
        if (dones != 1) begin
            n_fail++;
            $display("FAIL a5c3_done_count got %0d want 1", dones);
        end
    endtask

    task automatic test_ignore_load();
        logic [W-1:0] w;
        w = W'($urandom);
        a_din = w; a_load = 1'b1;
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            a_load = (k == 30);
            a_din  = (k == 30) ? 16'h1234 : W'($urandom);
            n_tests++;
            if ({a_sout, a_busy, a_done} !== {exp_sout(w, CPB_A, 1'b1, k), exp_busy(CPB_A, k), exp_done(CPB_A, k)}) begin
                n_fail++;
                $display("FAIL ignore_load k=%0d got %b%b%b want %b%b%b", k, a_sout, a_busy, a_done,
                         exp_sout(w, CPB_A, 1'b1, k), exp_busy(CPB_A, k), exp_done(CPB_A, k));
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] w;
        w = W'($urandom);
        a_din = w; a_load = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            a_load = 1'b0;
            n_tests++;
            if ({a_sout, a_busy} !== {exp_sout(w, CPB_A, 1'b1, k), exp_busy(CPB_A, k)}) begin
                n_fail++;
                $display("FAIL reset_mid_pre k=%0d got %b%b want %b%b", k, a_sout, a_busy,
                         exp_sout(w, CPB_A, 1'b1, k), exp_busy(CPB_A, k));
            end
        end
        a_reset = 1'b1;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            a_reset = 1'b0;
            n_tests++;
            if ({a_sout, a_busy, a_done} !== 3'b100) begin
                n_fail++;
                $display("FAIL reset_mid_abort k=%0d got %b%b%b want 100", k, a_sout, a_busy, a_done);
            end
        end
        w = 16'hFFFF;
        a_din = w; a_load = 1'b1;
        for (int k = 1; k <= 74; k++) begin
            @(negedge clk);
            a_load = 1'b0;
            n_tests++;
            if ({a_sout, a_busy, a_done} !== {exp_sout(w, CPB_A, 1'b1, k), exp_busy(CPB_A, k), exp_done(CPB_A, k)}) begin
                n_fail++;
                $display("FAIL reset_mid_ffff k=%0d got %b%b%b want %b%b%b", k, a_sout, a_busy, a_done,
                         exp_sout(w, CPB_A, 1'b1, k), exp_busy(CPB_A, k), exp_done(CPB_A, k));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] w;
        w = W'($urandom);
        a_din = w; a_load = 1'b1;
        for (int k = 1; k <= 73; k++) begin
            @(negedge clk);
            a_load = 1'b0;
            n_tests++;
            if ({a_sout, a_busy, a_done} !== {exp_sout(w, CPB_A, 1'b1, k), exp_busy(CPB_A, k), exp_done(CPB_A, k)}) begin
                n_fail++;
                $display("FAIL b2b_first k=%0d got %b%b%b want %b%b%b", k, a_sout, a_busy, a_done,
                         exp_sout(w, CPB_A, 1'b1, k), exp_busy(CPB_A, k), exp_done(CPB_A, k));
            end
        end
        w = 16'h0001;
        a_din = w; a_load = 1'b1;
        for (int k = 1; k <= 74; k++) begin
            @(negedge clk);
            a_load = 1'b0;
            n_tests++;
            if ({a_sout, a_busy, a_done} !== {exp_sout(w, CPB_A, 1'b1, k), exp_busy(CPB_A, k), exp_done(CPB_A, k)}) begin
                n_fail++;
                $display("FAIL b2b_second k=%0d got %b%b%b want %b%b%b", k, a_sout, a_busy, a_done,
                         exp_sout(w, CPB_A, 1'b1, k), exp_busy(CPB_A, k), exp_done(CPB_A, k));
            end
        end
    endtask

    task automatic test_lsb_cpb1();
        logic [W-1:0] w;
        w = 16'h8001;
        b_din = w; b_load = 1'b1;
        for (int k = 1; k <= 21; k++) begin
            @(negedge clk);
            b_load = 1'b0;
            b_din  = W'($urandom);
            n_tests++;
            if ({b_sout, b_busy, b_done} !== {exp_sout(w, CPB_B, 1'b0, k), exp_busy(CPB_B, k), exp_done(CPB_B, k)}) begin
                n_fail++;
                $display("FAIL lsb_cpb1 k=%0d got %b%b%b want %b%b%b", k, b_sout, b_busy, b_done,
                         exp_sout(w, CPB_B, 1'b0, k), exp_busy(CPB_B, k), exp_done(CPB_B, k));
            end
        end
    endtask

    task automatic test_reset_and_load();
        a_reset = 1'b1; a_load = 1'b1; a_din = 16'hBEEF;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            a_reset = 1'b0;
            a_load  = 1'b0;
            n_tests++;
            if ({a_sout, a_busy, a_done} !== 3'b100) begin
                n_fail++;
                $display("FAIL reset_and_load k=%0d got %b%b%b want 100", k, a_sout, a_busy, a_done);
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] w;
        for (int f = 0; f < 4; f++) begin
            w = W'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            a_din = w; a_load = 1'b1;
            for (int k = 1; k <= 73; k++) begin
                @(negedge clk);
                a_load = 1'b0;
                n_tests++;
                if ({a_sout, a_busy, a_done} !== {exp_sout(w, CPB_A, 1'b1, k), exp_busy(CPB_A, k), exp_done(CPB_A, k)}) begin
                    n_fail++;
                    $display("FAIL rand_a f=%0d k=%0d got %b%b%b want %b%b%b", f, k, a_sout, a_busy, a_done,
                             exp_sout(w, CPB_A, 1'b1, k), exp_busy(CPB_A, k), exp_done(CPB_A, k));
                end
            end
            w = W'($urandom);
            b_din = w; b_load = 1'b1;
            for (int k = 1; k <= 20; k++) begin
                @(negedge clk);
                b_load = 1'b0;
                n_tests++;
                if ({b_sout, b_busy, b_done} !== {exp_sout(w, CPB_B, 1'b0, k), exp_busy(CPB_B, k), exp_done(CPB_B, k)}) begin
                    n_fail++;
                    $display("FAIL rand_b f=%0d k=%0d got %b%b%b want %b%b%b", f, k, b_sout, b_busy, b_done,
                             exp_sout(w, CPB_B, 1'b0, k), exp_busy(CPB_B, k), exp_done(CPB_B, k));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_frame_a5c3();
        test_ignore_load();
        test_reset_mid();
        test_back_to_back();
        test_lsb_cpb1();
        test_reset_and_load();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired after %0d tests", n_tests);
        $fatal(1, "watchdog");
    end

endmodule : tb_reg_serial_tx
`default_nettype wire
